// File: rtl/dcache_ctrl_if.sv
// Bus between the CPU data port / data-memory decode and dcache_ctrl.
// The slave modport is the cache's view; master is the CPU plus memory side.
interface dcache_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      Addr;
    logic             MemRead;
    logic             MemWrite;
    logic [31:0]      WriteData;
    logic [31:0]      ReadData;
    logic             Stall;
    logic [31:0]      MemRdData;
    logic             memory_ready;
    logic             Hit;
    logic             MemWriteOut;
    logic [CNT_W-1:0] HitCount;
    logic [CNT_W-1:0] MissCount;

    modport slave (
        input  Addr, MemRead, MemWrite, WriteData, MemRdData, memory_ready,
        output ReadData, Stall, Hit, MemWriteOut, HitCount, MissCount
    );

    modport master (
        output Addr, MemRead, MemWrite, WriteData, MemRdData, memory_ready,
        input  ReadData, Stall, Hit, MemWriteOut, HitCount, MissCount
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines
// and saturating read hit/miss counters.
module dcache_ctrl #(
    parameter int N_LINES = 16,
    parameter int CNT_W   = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    dcache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(N_LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS_WAIT} state_t;

    state_t             state_q, state_d;
    logic [N_LINES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [N_LINES];
    logic [31:0]        data_q [N_LINES];
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               cacheable;
    logic               lookup_hit;
    logic               refill;
    logic               wr_update;
    logic               hit_c, stall_c, memwr_c;
    logic [31:0]        rdata_c;

    assign idx        = bus.Addr[IDX_W+1:2];
    assign tag        = bus.Addr[31:IDX_W+2];
    assign cacheable  = ((bus.Addr >= 32'h0000_0200) && (bus.Addr <= 32'h0000_03FF)) ||
                        ((bus.Addr >= 32'h0000_0800) && (bus.Addr <= 32'h0000_09FF));
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        hit_c      = 1'b1;
        stall_c    = 1'b0;
        memwr_c    = 1'b0;
        rdata_c    = '0;
        refill     = 1'b0;
        wr_update  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.MemWrite) begin
                    memwr_c   = 1'b1;
                    wr_update = cacheable && lookup_hit;
                end else if (bus.MemRead) begin
                    if (!cacheable) begin
                        rdata_c = bus.MemRdData;
                    end else if (lookup_hit) begin
                        rdata_c = data_q[idx];
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        hit_c   = 1'b0;
                        stall_c = 1'b1;
                        state_d = MISS_WAIT;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            MISS_WAIT: begin
                // Refill data is bypassed to the core in the ready cycle itself.
                hit_c = 1'b0;
                if (bus.memory_ready) begin
                    rdata_c = bus.MemRdData;
                    refill  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (refill) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (refill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= bus.MemRdData;
        end else if (wr_update) begin
            data_q[idx] <= bus.WriteData;
        end
    end

    assign bus.Hit         = hit_c;
    assign bus.Stall       = stall_c;
    assign bus.ReadData    = rdata_c;
    assign bus.MemWriteOut = memwr_c;
    assign bus.HitCount    = hit_cnt_q;
    assign bus.MissCount   = miss_cnt_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: word memory plus Hit-low counting ready generator,
// read results checked through a scoreboard queue.
module tb_dcache_ctrl;
    logic clk;
    logic rst_n;

    dcache_ctrl_if #(.CNT_W(16)) bus ();

    dcache_ctrl #(.N_LINES(16), .CNT_W(16)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] dmem [2048];
    logic [3:0]  mcnt;

    assign bus.MemRdData = dmem[bus.Addr[12:2]];

    always @(posedge clk) begin
        if (bus.MemWriteOut) dmem[bus.Addr[12:2]] <= bus.WriteData;
    end

    // Memory side: counts consecutive Hit-low cycles, pulses ready after count 5.
    always @(posedge clk) begin
        if (!rst_n || bus.Hit) begin
            mcnt             <= '0;
            bus.memory_ready <= 1'b0;
        end else begin
            mcnt             <= mcnt + 4'd1;
            bus.memory_ready <= (mcnt == 4'd5);
        end
    end

    typedef struct {
        logic [31:0] data;
        int          stall;
        int          hitlow;
    } sb_t;

    sb_t sb [$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int exp_stall);
        sb_t e;
        int  stall_n;
        int  hl_n;
        e.data   = exp;
        e.stall  = exp_stall;
        e.hitlow = (exp_stall != 0) ? exp_stall + 1 : 0;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.Addr     = a;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        stall_n = 0;
        hl_n    = 0;
        @(negedge clk);
        while (bus.Stall !== 1'b0 && stall_n < 40) begin
            stall_n++;
            if (bus.Hit !== 1'b1) hl_n++;
            @(negedge clk);
        end
        if (bus.Hit !== 1'b1) hl_n++;
        e = sb.pop_front();
        check($sformatf("rd_data@%h", a), bus.ReadData, e.data);
        check($sformatf("rd_stall@%h", a), 32'(stall_n), 32'(e.stall));
        check($sformatf("rd_hitlow@%h", a), 32'(hl_n), 32'(e.hitlow));
        @(posedge clk); #1;
        bus.MemRead = 1'b0;
        @(negedge clk);
        check("hit_after_rd", {31'd0, bus.Hit}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        @(negedge clk);
        check($sformatf("wr_strobe@%h", a), {31'd0, bus.MemWriteOut}, 32'd1);
        check($sformatf("wr_stall@%h", a), {31'd0, bus.Stall}, 32'd0);
        check($sformatf("wr_hit@%h", a), {31'd0, bus.Hit}, 32'd1);
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] h, input logic [15:0] m);
        check({tag, "_hits"}, {16'd0, bus.HitCount}, {16'd0, h});
        check({tag, "_misses"}, {16'd0, bus.MissCount}, {16'd0, m});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) dmem[i] = '0;
        dmem[32'h200 >> 2]  = 32'h0000_0810;
        dmem[32'h800 >> 2]  = 32'h1111_0800;
        dmem[32'h840 >> 2]  = 32'h2222_0840;
        dmem[32'h804 >> 2]  = 32'h3333_0804;
        dmem[32'h808 >> 2]  = 32'h4444_0808;
        dmem[32'h1000 >> 2] = 32'h5555_1000;
        rst_n         = 1'b0;
        bus.Addr      = '0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.WriteData = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_hit", {31'd0, bus.Hit}, 32'd1);
        check("rst_stall", {31'd0, bus.Stall}, 32'd0);
        check("rst_rdata", bus.ReadData, 32'd0);
        check("rst_memwr", {31'd0, bus.MemWriteOut}, 32'd0);
        check_counts("rst", 16'd0, 16'd0);

        do_read(32'h200, 32'h0000_0810, 6);
        do_read(32'h200, 32'h0000_0810, 0);
        check_counts("cold", 16'd1, 16'd1);

        do_read(32'h800, 32'h1111_0800, 6);
        do_read(32'h840, 32'h2222_0840, 6);
        do_read(32'h800, 32'h1111_0800, 6);
        check_counts("conflict", 16'd1, 16'd4);

        do_read(32'h804, 32'h3333_0804, 6);
        do_write(32'h804, 32'hDEAD_BEEF);
        check("wt_mem", dmem[32'h804 >> 2], 32'hDEAD_BEEF);
        dmem[32'h804 >> 2] = 32'h0;
        do_read(32'h804, 32'hDEAD_BEEF, 0);
        do_write(32'h808, 32'h1234_5678);
        do_read(32'h808, 32'h1234_5678, 6);
        check_counts("wt", 16'd2, 16'd6);

        do_read(32'h1000, 32'h5555_1000, 0);
        check_counts("uncached", 16'd2, 16'd6);

        // Reset in the middle of a refill wait.
        @(posedge clk); #1;
        bus.Addr    = 32'h200;
        bus.MemRead = 1'b1;
        @(negedge clk);
        check("midmiss_hit", {31'd0, bus.Hit}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.MemRead = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_hit", {31'd0, bus.Hit}, 32'd1);
        check("midrst_stall", {31'd0, bus.Stall}, 32'd0);
        check_counts("midrst", 16'd0, 16'd0);
        do_read(32'h200, 32'h0000_0810, 6);
        check_counts("post_rst", 16'd0, 16'd1);

        @(posedge clk); #1;
        bus.Addr    = 32'h200;
        bus.MemRead = 1'b1;
        repeat (65540) @(posedge clk);
        #1 bus.MemRead = 1'b0;
        @(negedge clk);
        check_counts("saturate", 16'hFFFF, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
